// File: rtl/exp_deintegrator_if.sv
// Sample stream handshake for the exponential de-integrator: the accepted
// input sample and the reconstructed output with its saturation flag.
interface exp_deintegrator_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_sat;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_sat
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_sat
  );
endinterface

// File: rtl/exp_deintegrator.sv
// Inverts y[n] = 3/4*x + 1/4*y[n-1]: x_est = floor((4*y - y_prev)/3), computed
// with a bit-serial restoring divide-by-3 and clamped to the output range.
module exp_deintegrator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  exp_deintegrator_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int QW = W + 2;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

  state_t          state;
  logic [W-1:0]    y_prev;
  logic [QW-1:0]   dvd;
  logic [QW-1:0]   quo;
  logic [1:0]      rem;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            ready_q;
  logic            valid_q;
  logic [W-1:0]    data_q;
  logic            sat_q;

  // 4*y never exceeds 2^(W+2)-4, so one extra sign bit makes N exact.
  logic signed [W+2:0] num;
  assign num = $signed({1'b0, bus.i_data, 2'b00}) - $signed({3'b000, y_prev});

  logic [2:0] trial;
  logic [2:0] trial_sub;
  logic       ge;
  logic [1:0] rem_nxt;

  always_comb begin
    trial     = {rem, dvd[QW-1]};
    trial_sub = trial - 3'd3;
    ge        = (trial >= 3'd3);
    rem_nxt   = ge ? trial_sub[1:0] : trial[1:0];
  end

  logic ovf;
  assign ovf = |quo[QW-1:W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      y_prev  <= '0;
      dvd     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid && ready_q) begin
            y_prev  <= bus.i_data;
            // Non-positive N divides a zero dividend so latency stays fixed.
            dvd     <= (!num[W+2] && (|num)) ? num[QW-1:0] : '0;
            neg     <= num[W+2];
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= DIV;
          end
        end
        DIV: begin
          if (cnt == CW'(QW)) begin
            data_q  <= neg ? '0 : (ovf ? '1 : quo[W-1:0]);
            sat_q   <= neg | ovf;
            valid_q <= 1'b1;
            state   <= OUT;
          end else begin
            dvd <= {dvd[QW-2:0], 1'b0};
            quo <= {quo[QW-2:0], ge};
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_sat   = sat_q;
endmodule

// File: tb/tb_exp_deintegrator.sv
// Directed and randomized checks of exp_deintegrator against an arithmetic
// model of x = floor((4*y - y_prev)/3) with clamping.
module tb_exp_deintegrator;
  localparam int W   = 16;
  localparam int LAT = W + 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   y_prev_m = 0;

  exp_deintegrator_if #(.DATA_WIDTH(W)) bus ();

  exp_deintegrator #(.DATA_WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int y, input int yp, output int d, output int s);
    int n;
    int q;
    n = 4 * y - yp;
    if (n < 0) begin
      d = 0; s = 1;
    end else begin
      q = n / 3;
      if (q > (1 << W) - 1) begin d = (1 << W) - 1; s = 1; end
      else begin d = q; s = 0; end
    end
  endfunction

  // Offer one sample, then hold i_ready low for 'hold' cycles of OUT while
  // pulsing i_valid with junk that must not be consumed.
  task automatic send(input int y, input int hold, input string tag);
    int ed, es, cnt;
    model(y, y_prev_m, ed, es);
    bus.i_ready = (hold == 0);
    bus.i_data  = y[W-1:0];
    bus.i_valid = 1'b1;
    check({tag, ".ready_in"}, longint'(bus.o_ready), 1);
    step();
    y_prev_m    = y;
    bus.i_valid = 1'b0;
    bus.i_data  = W'($urandom);
    cnt = 0;
    while (!bus.o_valid && cnt < 2 * LAT) begin
      step();
      cnt++;
      bus.i_data = W'($urandom);
    end
    check({tag, ".latency"}, cnt, LAT);
    check({tag, ".data"}, longint'(bus.o_data), ed);
    check({tag, ".sat"}, longint'(bus.o_sat), es);
    for (int i = 0; i < hold; i++) begin
      bus.i_valid = i[0];
      bus.i_data  = W'($urandom);
      step();
      check({tag, ".hold_valid"}, longint'(bus.o_valid), 1);
      check({tag, ".hold_data"}, longint'(bus.o_data), ed);
      check({tag, ".hold_sat"}, longint'(bus.o_sat), es);
      check({tag, ".hold_ready"}, longint'(bus.o_ready), 0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    step();
    check({tag, ".post_valid"}, longint'(bus.o_valid), 0);
    check({tag, ".post_ready"}, longint'(bus.o_ready), 1);
    check({tag, ".post_data"}, longint'(bus.o_data), ed);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    y_prev_m = 0;
  endtask

  initial begin
    int y, hold, seen;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    do_reset();
    check("rst.ready", longint'(bus.o_ready), 1);
    check("rst.valid", longint'(bus.o_valid), 0);
    check("rst.data", longint'(bus.o_data), 0);
    check("rst.sat", longint'(bus.o_sat), 0);

    send(300, 0, "y300_first");
    check("y300_first.abs", longint'(bus.o_data), 400);
    send(300, 0, "y300_second");
    check("y300_second.abs", longint'(bus.o_data), 300);
    send(301, 0, "y301");
    check("y301.abs", longint'(bus.o_data), 301);
    send(300, 0, "y300_after301");
    send(0, 0, "y0_neg");
    check("y0_neg.abs_sat", longint'(bus.o_sat), 1);
    send(0, 0, "y0_zero");
    check("y0_zero.abs_sat", longint'(bus.o_sat), 0);

    do_reset();
    send(65535, 0, "ymax");
    check("ymax.abs", longint'(bus.o_data), 65535);

    // Stalled output with ignored i_valid pulses; y_prev must stay 1234.
    send(1234, 10, "stall");
    send(1234, 0, "after_stall");

    // Abort 5 cycles into DIV; reset also overrides a simultaneous offer.
    bus.i_data  = 16'd1234;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 16'd999;
    step();
    check("abort.valid", longint'(bus.o_valid), 0);
    check("abort.data", longint'(bus.o_data), 0);
    check("abort.sat", longint'(bus.o_sat), 0);
    check("abort.ready", longint'(bus.o_ready), 1);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    y_prev_m = 0;
    seen = 0;
    repeat (2 * LAT) begin
      step();
      if (bus.o_valid) seen++;
    end
    check("abort.no_valid", seen, 0);
    send(300, 0, "abort_next");
    check("abort_next.abs", longint'(bus.o_data), 400);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: y = 0;
        1: y = 65535 - $urandom_range(0, 3);
        default: y = $urandom_range(0, 65535);
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      repeat ($urandom_range(0, 2)) begin
        bus.i_data = W'($urandom);
        step();
      end
      send(y, hold, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exp_deintegrator.md
EXP_DEINTEGRATOR -- requirements
Module: exp_deintegrator

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width W of the sample bus; legal range 8..32.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_data  input  W  unsigned smoothed sample y[n] from the exponential integrator.
REQ-005 i_valid  input  1  i_data valid.
REQ-006 o_ready  output  1  block can accept a sample this cycle.
REQ-007 o_data  output  W  unsigned reconstructed input estimate x_est.
REQ-008 o_valid  output  1  o_data/o_sat valid.
REQ-009 i_ready  input  1  downstream accepts o_data this cycle.
REQ-010 o_sat  output  1  result was clamped (low or high) for the current o_data.

Function
REQ-011 Block SHALL invert y[n] = 3/4*x + 1/4*y[n-1]: x_est = floor((4*y[n] - y_prev) / 3), y_prev = previously accepted sample.
REQ-012 Input accept SHALL occur at an edge where i_valid=1 and o_ready=1; i_data latched, y_prev updated to i_data at the same edge.
REQ-013 y_prev SHALL be 0 for the first sample after reset.
REQ-014 Numerator N SHALL be computed as a signed value of W+3 bits, no overflow possible.
REQ-015 If N <= 0: o_data=0, o_sat=1 when N<0, o_sat=0 when N=0; divider still runs full length (fixed latency).
REQ-016 If N > 0: quotient via restoring serial divide by 3, one quotient bit per cycle, W+2 quotient bits, floor rounding.
REQ-017 If quotient > 2^W-1: o_data=2^W-1, o_sat=1; else o_data=quotient, o_sat=0.
REQ-018 FSM states: IDLE, DIV, OUT.
REQ-019 IDLE: o_ready=1, o_valid=0; accept -> DIV.
REQ-020 DIV: o_ready=0; bit counter counts W+2 cycles, then -> OUT.
REQ-021 OUT: o_valid=1, o_ready=0; o_data/o_sat held stable until i_ready=1; at edge with i_ready=1 -> IDLE.
REQ-022 Latency: o_valid SHALL be high exactly W+3 cycles after the accepting edge (19 for W=16) when i_ready was high beforehand.
REQ-023 Throughput: at most one sample per W+4 cycles; no accept in DIV or OUT.
REQ-024 i_valid while o_ready=0 SHALL be ignored (not consumed, y_prev unchanged); source holds per valid/ready rules.
REQ-025 i_data changes while not accepted SHALL have no effect.
REQ-026 o_data/o_sat SHALL keep last result after OUT->IDLE until the next result is loaded.

Reset
REQ-027 On i_rst=1 at an edge: state=IDLE, o_valid=0, o_ready=1 next cycle, o_data=0, o_sat=0, y_prev=0, divider regs/counter cleared.
REQ-028 Reset SHALL take priority over accept, divide step and output handshake in the same cycle.
REQ-029 Reset mid-DIV or in OUT SHALL abort the operation; no o_valid pulse for the aborted sample.

Verification (W=16)
REQ-030 Reset, send y=300 (y_prev=0) -> N=1200, o_data=400, o_sat=0, o_valid 19 cycles after accept.
REQ-031 Follow with y=300 -> N=900, o_data=300, o_sat=0; then y=301 -> N=904, o_data=301.
REQ-032 y=300 then y=0 -> N=-300, o_data=0, o_sat=1.
REQ-033 From reset, y=65535 -> N=262140, quotient 87380 -> o_data=65535, o_sat=1.
REQ-034 Hold i_ready=0 for 10 cycles in OUT -> o_valid, o_data, o_sat stable, o_ready=0; i_valid pulses meanwhile not consumed (y_prev unchanged); i_ready=1 -> IDLE next cycle.
REQ-035 Assert i_rst 5 cycles into DIV -> no o_valid, all outputs 0 next cycle; next y=300 yields o_data=400 (y_prev=0).
